pulse_shaper: RTL

PULSE_SHAPER -- requirements
Module: pulse_shaper

---
 rtl/pulse_shaper.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pulse_shaper.sv
// pulse_shaper
//   Turns single-cycle request pulses into clean fixed-width high windows.
//   Each accepted request produces exactly hightime cycles of shaped=1,
//   always followed by at least lowtime cycles of shaped=0. Requests that
//   arrive while a window or gap is in progress are queued in a saturating
//   counter; a request that finds the queue full is lost and flagged.
//
// Ports
//   clk      in   sole clock, rising edge
//   reset    in   synchronous, active-high; clears all state
//   trigger  in   request pulse (clk domain), one request per high cycle
//   shaped   out  registered output level, one high window per request
//   busy     out  registered, 1 while a window or its gap is in progress
//   pending  out  registered count of queued requests not yet started
//   dropped  out  registered one-cycle pulse when a request is lost
module pulse_shaper #(
   parameter int counterwidth = 4,
   parameter int hightime     = 4,
   parameter int lowtime      = 4,
   parameter int pendwidth    = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 trigger,
   output logic                 shaped,
   output logic                 busy,
   output logic [pendwidth-1:0] pending,
   output logic                 dropped
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [counterwidth-1:0] TIMER_ONE = counterwidth'(1);
   localparam logic [counterwidth-1:0] HIGH_END  = counterwidth'(hightime);
   localparam logic [counterwidth-1:0] LOW_END   = counterwidth'(lowtime);
   localparam logic [pendwidth-1:0]    PEND_ONE  = pendwidth'(1);
   localparam logic [pendwidth-1:0]    PEND_MAX  = '1;

   state_t                 state;
   state_t                 state_nxt;
   logic [counterwidth-1:0] timer;
   logic [counterwidth-1:0] timer_nxt;
   logic [pendwidth-1:0]    pending_nxt;
   logic                    dropped_nxt;

   // Saturating queue increment. The MSB of the result flags that the
   // queue was already full and the request has to be discarded.
   function automatic logic [pendwidth:0] pend_sat_inc(input logic [pendwidth-1:0] p);
      logic [pendwidth:0] r;
      if (p == PEND_MAX) begin
         r = {1'b1, p};
      end else begin
         r = {1'b0, p + PEND_ONE};
      end
      return r;
   endfunction

   // Next-state, timer and queue logic
   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      pending_nxt = pending;
      dropped_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (trigger) begin
               state_nxt = HIGH;
               timer_nxt = TIMER_ONE;
            end
         end
         HIGH: begin
            if (trigger) begin
               {dropped_nxt, pending_nxt} = pend_sat_inc(pending);
            end
            if (timer == HIGH_END) begin
               state_nxt = GAP;
               timer_nxt = TIMER_ONE;
            end else begin
               timer_nxt = timer + TIMER_ONE;
            end
         end
         GAP: begin
            if (timer == LOW_END) begin
               if (pending != '0) begin
                  // Start the oldest queued request; a simultaneous new
                  // trigger takes the slot it frees, so the count is unchanged.
                  state_nxt = HIGH;
                  timer_nxt = TIMER_ONE;
                  if (!trigger) begin
                     pending_nxt = pending - PEND_ONE;
                  end
               end else if (trigger) begin
                  // Empty queue: the coincident trigger starts directly.
                  state_nxt = HIGH;
                  timer_nxt = TIMER_ONE;
               end else begin
                  state_nxt = IDLE;
                  timer_nxt = '0;
               end
            end else begin
               timer_nxt = timer + TIMER_ONE;
               if (trigger) begin
                  {dropped_nxt, pending_nxt} = pend_sat_inc(pending);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            timer_nxt = '0;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         timer   <= '0;
         shaped  <= 1'b0;
         busy    <= 1'b0;
         pending <= '0;
         dropped <= 1'b0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         shaped  <= (state_nxt == HIGH);
         busy    <= (state_nxt != IDLE);
         pending <= pending_nxt;
         dropped <= dropped_nxt;
      end
   end

endmodule
